// File: rtl/vec_dot_product_seq.sv
// Sequential 8-lane unsigned dot product over a job of `len` 64-bit chunks.
//
// Each accepted chunk is reduced to a 19-bit partial sum (8 products summed
// as a balanced 8->4->2->1 tree) and registered. On the following edge that
// partial sum is added to the accumulator. The FSM walks IDLE -> RUN ->
// DRAIN -> DONE. DRAIN is the one cycle needed to fold in the last partial.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   start      job request, honoured only in IDLE
//   len        chunk count, sampled with an accepted start (0 = empty job)
//   abort      synchronous cancel, highest priority after reset
//   in_valid   chunk operands valid
//   in_ready   chunk accepted this cycle when in_valid is also high (RUN only)
//   vec_a      eight unsigned 8-bit lanes, lane i at [8i+7:8i]
//   vec_b      eight unsigned 8-bit lanes, lane i at [8i+7:8i]
//   res_valid  result available (DONE only)
//   res_ready  consumer takes the result
//   res_data   accumulator value; the job result while res_valid is high
//   busy       high in every state except IDLE
module vec_dot_product_seq #(
    parameter int unsigned  LEN_W = 8,
    localparam int unsigned ACC_W = 19 + LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      vec_a,
    input  logic [63:0]      vec_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [18:0]      psum_q, psum_d;
    logic             pvalid_q, pvalid_d;

    logic             accept;
    logic [15:0]      prod [8];
    logic [16:0]      sum4 [4];
    logic [17:0]      sum2 [2];
    logic [18:0]      tree_sum;

    // Balanced reduction tree; each level widens by one bit so nothing overflows.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            prod[i] = 16'(vec_a[8*i +: 8]) * 16'(vec_b[8*i +: 8]);
        end
        for (int i = 0; i < 4; i++) begin
            sum4[i] = 17'(prod[2*i]) + 17'(prod[2*i+1]);
        end
        for (int i = 0; i < 2; i++) begin
            sum2[i] = 18'(sum4[2*i]) + 18'(sum4[2*i+1]);
        end
        tree_sum = 19'(sum2[0]) + 19'(sum2[1]);
    end

    assign accept = in_valid && (state_q == StRun) && !abort;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        acc_d       = acc_q;
        psum_d      = psum_q;
        pvalid_d    = accept;

        if (pvalid_q) begin
            acc_d = acc_q + ACC_W'(psum_q);
        end
        if (accept) begin
            psum_d = tree_sum;
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d = '0;
                    if (len == '0) begin
                        state_d = StDone;
                    end else begin
                        remaining_d = len;
                        state_d     = StRun;
                    end
                end
            end
            StRun: begin
                if (accept) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                state_d = StDone;
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort cancels everything, including a partial sum still in flight.
        if (abort) begin
            state_d     = StIdle;
            remaining_d = '0;
            acc_d       = acc_q;
            pvalid_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            acc_q       <= '0;
            psum_q      <= '0;
            pvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            acc_q       <= acc_d;
            psum_q      <= psum_d;
            pvalid_q    <= pvalid_d;
        end
    end

    assign in_ready  = (state_q == StRun);
    assign res_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign res_data  = acc_q;

endmodule
